// File: rtl/skinny_mask_pkg.sv
// Shared types and helpers for the nibble-serial masked SKINNY-64 S-box scheduler.
package skinny_mask_pkg;

  localparam int SHARES      = 3;
  localparam int NIBBLE_W    = 4;
  localparam int MAX_NIBBLES = 64;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    FIN
  } sched_state_t;

  // Callers zero-pad narrower states up to MAX_NIBBLES nibbles.
  function automatic logic [NIBBLE_W-1:0] nibble_sel(
    input logic [NIBBLE_W*MAX_NIBBLES-1:0] vec,
    input int                              idx
  );
    return vec[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/sched_valid_pipe.sv
// Valid-bit shift register tracking which masked S-box pipeline slots hold real nibbles.
module sched_valid_pipe #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic tail
);

  logic [STAGES-1:0] pipe_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_reg[gi] <= 1'b0;
      end else if (en) begin
        if (gi == 0) begin
          pipe_reg[gi] <= din;
        end else begin
          pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  end

  assign tail = pipe_reg[STAGES-1];

endmodule

// File: rtl/masked_sbox_sched.sv
// Nibble-serial scheduler feeding one shared 3-share masked S-box and writing results back in place.
// Optional macro SBOX_IDLE_ZERO_EN: drive zero S-box inputs whenever the FSM is not in FEED.
module masked_sbox_sched
  import skinny_mask_pkg::*;
#(
  parameter int NIBBLES = 16,
  parameter int STAGES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NIBBLES-1:0]    state_in_s0,
  input  logic [4*NIBBLES-1:0]    state_in_s1,
  input  logic [4*NIBBLES-1:0]    state_in_s2,
  output logic                    busy,
  output logic                    done,
  output logic [4*NIBBLES-1:0]    state_out_s0,
  output logic [4*NIBBLES-1:0]    state_out_s1,
  output logic [4*NIBBLES-1:0]    state_out_s2,
  output logic                    sbox_en,
  output logic [3:0]              sbox_in_s0,
  output logic [3:0]              sbox_in_s1,
  output logic [3:0]              sbox_in_s2,
  input  logic [3:0]              sbox_out_s0,
  input  logic [3:0]              sbox_out_s1,
  input  logic [3:0]              sbox_out_s2
);

  localparam int STATE_W = NIBBLE_W * NIBBLES;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  sched_state_t     state_reg;
  logic [IDX_W-1:0] rd_idx_reg;
  logic [IDX_W-1:0] wr_idx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             tail;
  int               rd_sel;

  logic [STATE_W-1:0]  in_share       [SHARES];
  logic [STATE_W-1:0]  out_share      [SHARES];
  logic [NIBBLE_W-1:0] sbox_in_share  [SHARES];
  logic [NIBBLE_W-1:0] sbox_out_share [SHARES];

  assign in_share[0]       = state_in_s0;
  assign in_share[1]       = state_in_s1;
  assign in_share[2]       = state_in_s2;
  assign sbox_out_share[0] = sbox_out_s0;
  assign sbox_out_share[1] = sbox_out_s1;
  assign sbox_out_share[2] = sbox_out_s2;

  assign state_out_s0 = out_share[0];
  assign state_out_s1 = out_share[1];
  assign state_out_s2 = out_share[2];
  assign sbox_in_s0   = sbox_in_share[0];
  assign sbox_in_s1   = sbox_in_share[1];
  assign sbox_in_s2   = sbox_in_share[2];

  assign busy    = busy_reg;
  assign sbox_en = busy_reg;
  assign done    = done_reg;

  always_comb begin
    rd_sel = int'(rd_idx_reg);
    if (rd_sel > NIBBLES - 1) begin
      rd_sel = NIBBLES - 1;
    end
  end

  sched_valid_pipe #(
    .STAGES (STAGES)
  ) u_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_reg),
    .din  (state_reg == FEED),
    .tail (tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rd_idx_reg <= '0;
      wr_idx_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= FEED;
            rd_idx_reg <= '0;
            wr_idx_reg <= '0;
            busy_reg   <= 1'b1;
          end
        end
        FEED: begin
          if (rd_idx_reg == LAST) begin
            state_reg <= DRAIN;
          end else begin
            rd_idx_reg <= rd_idx_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (tail && (wr_idx_reg == LAST)) begin
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
      // Results can already return while later nibbles are still being fed.
      if (tail && (wr_idx_reg != LAST)) begin
        wr_idx_reg <= wr_idx_reg + 1'b1;
      end
    end
  end

  // Each share has its own source, mux and write-back path; only the indices are shared.
  for (genvar gi = 0; gi < SHARES; gi++) begin : g_share
    logic [STATE_W-1:0]              src_reg;
    logic [STATE_W-1:0]              out_reg;
    logic [NIBBLE_W*MAX_NIBBLES-1:0] src_pad;
    logic [NIBBLE_W-1:0]             sel_nib;

    always_comb begin
      src_pad                 = '0;
      src_pad[STATE_W-1:0]    = src_reg;
`ifdef SBOX_IDLE_ZERO_EN
      sel_nib = (state_reg == FEED) ? nibble_sel(src_pad, rd_sel) : '0;
`else
      sel_nib = nibble_sel(src_pad, rd_sel);
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        src_reg <= '0;
        out_reg <= '0;
      end else begin
        if ((state_reg == IDLE) && start) begin
          src_reg <= in_share[gi];
        end
        if (tail) begin
          out_reg[int'(wr_idx_reg)*NIBBLE_W +: NIBBLE_W] <= sbox_out_share[gi];
        end
      end
    end

    assign sbox_in_share[gi] = sel_nib;
    assign out_share[gi]     = out_reg;
  end

endmodule

// File: tb/tb_masked_sbox_sched.sv
// Scoreboard bench for masked_sbox_sched with a behavioural 4-stage S-box stub (identity, +1, masked SKINNY).
module tb_masked_sbox_sched;

  localparam int NIBBLES = 16;
  localparam int STAGES  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] in0 = '0, in1 = '0, in2 = '0;
  logic        busy, done, sbox_en;
  logic [63:0] out0, out1, out2;
  logic [3:0]  sin0, sin1, sin2;
  logic [3:0]  sout0, sout1, sout2;

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  typedef struct {
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] e2;
    bit          xor_only;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  masked_sbox_sched #(
    .NIBBLES (NIBBLES),
    .STAGES  (STAGES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .state_in_s0  (in0),
    .state_in_s1  (in1),
    .state_in_s2  (in2),
    .busy         (busy),
    .done         (done),
    .state_out_s0 (out0),
    .state_out_s1 (out1),
    .state_out_s2 (out2),
    .sbox_en      (sbox_en),
    .sbox_in_s0   (sin0),
    .sbox_in_s1   (sin1),
    .sbox_in_s2   (sin2),
    .sbox_out_s0  (sout0),
    .sbox_out_s1  (sout1),
    .sbox_out_s2  (sout2)
  );

  function automatic logic [3:0] skinny_s(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
      4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
      4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
      4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] sbox_vec(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[k*4 +: 4] = skinny_s(v[k*4 +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] add1_vec(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[k*4 +: 4] = v[k*4 +: 4] + 4'h1;
    return r;
  endfunction

  function automatic logic [3:0] nib(input logic [63:0] v, input int k);
    return v[k*4 +: 4];
  endfunction

  // Behavioural S-box pipeline: mode 0 identity, 1 adds 1 on share 0, 2 remasked SKINNY S-box.
  logic [3:0] st0 [STAGES];
  logic [3:0] st1 [STAGES];
  logic [3:0] st2 [STAGES];
  logic [3:0] n0, n1, n2, r1, r2;

  always @(posedge clk) begin
    if (sbox_en) begin
      case (mode)
        1: begin n0 = sin0 + 4'h1; n1 = sin1; n2 = sin2; end
        2: begin
          r1 = 4'($urandom_range(0, 15));
          r2 = 4'($urandom_range(0, 15));
          n0 = skinny_s(sin0 ^ sin1 ^ sin2) ^ r1 ^ r2;
          n1 = r1;
          n2 = r2;
        end
        default: begin n0 = sin0; n1 = sin1; n2 = sin2; end
      endcase
      st0[0] <= n0; st1[0] <= n1; st2[0] <= n2;
      for (int i = 1; i < STAGES; i++) begin
        st0[i] <= st0[i-1]; st1[i] <= st1[i-1]; st2[i] <= st2[i-1];
      end
    end
  end

  assign sout0 = st0[STAGES-1];
  assign sout1 = st1[STAGES-1];
  assign sout2 = st2[STAGES-1];

  task automatic check_outputs(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: done with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    if (e.xor_only) begin
      total++;
      if ((out0 ^ out1 ^ out2) !== e.e0) begin
        bad++;
        $display("FAIL %s xor: got %h want %h", name, out0 ^ out1 ^ out2, e.e0);
      end
      total++;
      if (out0 === e.e0) begin
        bad++;
        $display("FAIL %s share0 unmasked: got %h must differ from %h", name, out0, e.e0);
      end
    end else begin
      total++;
      if ({out2, out1, out0} !== {e.e2, e.e1, e.e0}) begin
        bad++;
        $display("FAIL %s shares: got %h_%h_%h want %h_%h_%h", name,
                 out2, out1, out0, e.e2, e.e1, e.e0);
      end
    end
  endtask

  // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle 25.
  task automatic run_op(input string name, input logic [63:0] a, b, c, input int m);
    exp_t e;
    int done_cnt = 0, done_cyc = -1, busy_cnt = 0, busy_first = -1, busy_last = -1;
    int en_err = 0, in_err = 0;
    mode = m;
    case (m)
      1:       e = '{add1_vec(a), b, c, 1'b0};
      2:       e = '{sbox_vec(a ^ b ^ c), 64'h0, 64'h0, 1'b1};
      default: e = '{a, b, c, 1'b0};
    endcase
    sb.push_back(e);
    in0 = a; in1 = b; in2 = c; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (sbox_en !== busy) en_err++;
      if (cyc <= NIBBLES) begin
        if ({sin2, sin1, sin0} !== {nib(c, cyc-1), nib(b, cyc-1), nib(a, cyc-1)}) in_err++;
      end
`ifdef SBOX_IDLE_ZERO_EN
      else if ({sin2, sin1, sin0} !== 12'h000) in_err++;
`endif
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        check_outputs(name);
      end
      @(posedge clk); #1;
    end
    if (done_cnt == 0 && sb.size() > 0) void'(sb.pop_front());
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL %s done count: got %0d want 1", name, done_cnt); end
    total++;
    if (done_cyc !== 21) begin bad++; $display("FAIL %s done cycle: got %0d want 21", name, done_cyc); end
    total++;
    if ({busy_cnt, busy_first, busy_last} !== {32'sd20, 32'sd1, 32'sd20}) begin
      bad++;
      $display("FAIL %s busy window: got cnt=%0d first=%0d last=%0d want 20/1/20",
               name, busy_cnt, busy_first, busy_last);
    end
    total++;
    if (en_err !== 0) begin bad++; $display("FAIL %s sbox_en: got %0d mismatching cycles want 0", name, en_err); end
    total++;
    if (in_err !== 0) begin bad++; $display("FAIL %s sbox_in: got %0d wrong cycles want 0", name, in_err); end
    $display("op %s: done_cycle=%0d out0=%h out1=%h out2=%h", name, done_cyc, out0, out1, out2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, sbox_en} !== 3'b000) begin
      bad++; $display("FAIL reset flags: got %b want 000", {busy, done, sbox_en});
    end
    total++;
    if ({out2, out1, out0} !== 192'h0) begin
      bad++; $display("FAIL reset state_out: got %h_%h_%h want 0", out2, out1, out0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("op reset: busy=%b done=%b", busy, done);
  endtask

  task automatic test_identity();
    run_op("identity", 64'h0123456789ABCDEF, 64'h0, 64'h0, 0);
    run_op("identity_rand", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0);
  endtask

  task automatic test_masked();
    logic [63:0] a, b, s;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    run_op("masked_zero", a, b, a ^ b, 2);
    s = {$urandom, $urandom}; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    run_op("masked_rand", a, b, s ^ a ^ b, 2);
  endtask

  task automatic test_order();
    run_op("order_add1", 64'hFEDCBA9876543210, 64'h5A5A5A5A5A5A5A5A, 64'h3C3C3C3C3C3C3C3C, 1);
  endtask

  task automatic test_back_to_back();
    int dcnt = 0;
    int dcyc[3] = '{-1, -1, -1};
    logic b22 = 1'bx, b23 = 1'bx;
    mode = 0;
    in0 = 64'hA5A5_0F0F_1234_CDEF; in1 = 64'h1; in2 = 64'h2;
    for (int i = 0; i < 3; i++) sb.push_back('{in0, in1, in2, 1'b0});
    start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (cyc == 66) start = 1'b0;
      @(negedge clk);
      if (cyc == 22) b22 = busy;
      if (cyc == 23) b23 = busy;
      if (done === 1'b1) begin
        if (dcnt < 3) dcyc[dcnt] = cyc;
        dcnt++;
        check_outputs("back_to_back");
      end
      @(posedge clk); #1;
    end
    sb.delete();
    total++;
    if (dcnt !== 3) begin bad++; $display("FAIL b2b done count: got %0d want 3", dcnt); end
    total++;
    if ({dcyc[0], dcyc[1], dcyc[2]} !== {32'sd21, 32'sd43, 32'sd65}) begin
      bad++; $display("FAIL b2b done cycles: got %0d,%0d,%0d want 21,43,65", dcyc[0], dcyc[1], dcyc[2]);
    end
    total++;
    if ({b22, b23} !== 2'b01) begin
      bad++; $display("FAIL b2b restart: got busy22=%b busy23=%b want 0,1", b22, b23);
    end
    $display("op back_to_back: dones=%0d at %0d,%0d,%0d", dcnt, dcyc[0], dcyc[1], dcyc[2]);
  endtask

  task automatic test_abort();
    int dcnt = 0;
    logic b9 = 1'bx;
    logic b11 = 1'bx;
    logic [191:0] o11 = 'x;
    mode = 0;
    in0 = 64'hDEADBEEFCAFEF00D; in1 = 64'h0; in2 = 64'h0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 10) rst = 1'b1;
      if (cyc == 11) rst = 1'b0;
      @(negedge clk);
      if (cyc == 9) b9 = busy;
      if (cyc == 11) begin b11 = busy; o11 = {out2, out1, out0}; end
      if (done === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    total++;
    if ({b9, b11} !== 2'b10) begin bad++; $display("FAIL abort busy: got c9=%b c11=%b want 1,0", b9, b11); end
    total++;
    if (o11 !== 192'h0) begin bad++; $display("FAIL abort state_out: got %h want 0", o11); end
    total++;
    if (dcnt !== 0) begin bad++; $display("FAIL abort done: got %0d pulses want 0", dcnt); end
    $display("op abort: dones=%0d", dcnt);
    run_op("after_abort", 64'h13579BDF02468ACE, 64'h0, 64'hFFFF0000FFFF0000, 0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_masked();
    test_order();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
